// File: rtl/generic_fifo_sc_thr.sv
// generic_fifo_sc_thr
// -------------------
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// a registered fill level, sticky overflow / underflow flags, a synchronous
// flush (clear) and a selectable standard or first-word-fall-through read.
//
// Parameters:
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  log2 of the depth (depth = 2**ADDR_WIDTH)
//   FWFT        0: pop_data registered on an accepted pop, pop_valid pulses
//               1: head word shown combinationally, pop_valid = !empty
//   AFULL_THR   almost_full  when fill_level >= AFULL_THR
//   AEMPTY_THR  almost_empty when fill_level <= AEMPTY_THR
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous flush, wins over push/pop
//   push         write request, push_data is the word written
//   pop          read request, pop_data / pop_valid carry the word read
//   full, empty, almost_full, almost_empty   compares on fill_level
//   fill_level   occupancy 0 .. 2**ADDR_WIDTH
//   overflow     sticky: push attempted while full (and not popping)
//   underflow    sticky: pop attempted while empty
//
// Optional build macro FIFO_STATS_EN adds:
//   peak_level   high-water mark of fill_level
//   drop_count   saturating count of rejected pushes
module generic_fifo_sc_thr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]   peak_level,
  output logic [15:0]           drop_count
`endif
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_L  = AFULL_THR[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = AEMPTY_THR[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Reject illegal threshold configurations at elaboration.
  generate
    if (!((AEMPTY_THR >= 0) && (AEMPTY_THR < AFULL_THR) && (AFULL_THR <= DEPTH))) begin : g_bad_cfg
      $error("generic_fifo_sc_thr: need 0 <= AEMPTY_THR < AFULL_THR <= 2**ADDR_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] fill_q,   fill_d;
  logic                overflow_q,  overflow_d;
  logic                underflow_q, underflow_d;

  logic full_s, empty_s;
  logic push_acc_s, pop_acc_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;

  // Status flags decode the registered fill count only, so they never glitch.
  assign full_s       = (fill_q == DEPTH_L);
  assign empty_s      = (fill_q == PTR_ZERO);
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (fill_q >= AFULL_L);
  assign almost_empty = (fill_q <= AEMPTY_L);
  assign fill_level   = fill_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_addr_s = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr_s = rd_ptr_q[ADDR_WIDTH-1:0];

  // Accept decisions and next-state for pointers, fill count and sticky flags.
  always_comb begin
    // Pop never bypasses: an empty FIFO rejects it even with a push alongside.
    pop_acc_s   = pop && !empty_s;
    // A full FIFO still takes a push when the same cycle frees a slot.
    push_acc_s  = push && (!full_s || pop_acc_s);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      fill_d      = PTR_ZERO;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_acc_s, pop_acc_s})
        2'b10:   fill_d = fill_q + PTR_ONE;
        2'b01:   fill_d = fill_q - PTR_ONE;
        default: fill_d = fill_q;
      endcase
      overflow_d  = overflow_q  | (push && !push_acc_s);
      underflow_d = underflow_q | (pop && empty_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      fill_q      <= PTR_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; the array itself is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (push_acc_s && !clear) begin
      mem_q[wr_addr_s] <= push_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads 0.
      assign pop_valid = !empty_s;
      assign pop_data  = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_addr_s];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] pop_data_q;
      logic                  pop_valid_q;

      // Registered read: word captured on the pop edge, valid pulses one cycle.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pop_data_q  <= {DATA_WIDTH{1'b0}};
          pop_valid_q <= 1'b0;
        end else if (clear) begin
          pop_valid_q <= 1'b0;
        end else begin
          pop_valid_q <= pop_acc_s;
          if (pop_acc_s) begin
            pop_data_q <= mem_q[rd_addr_s];
          end
        end
      end

      assign pop_data  = pop_data_q;
      assign pop_valid = pop_valid_q;
    end
  endgenerate

`ifdef FIFO_STATS_EN
  logic [ADDR_WIDTH:0] peak_q;
  logic [15:0]         drop_q;

  // High-water mark follows the fill count it will hold next cycle;
  // the drop counter saturates instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= PTR_ZERO;
      drop_q <= 16'h0000;
    end else if (clear) begin
      peak_q <= PTR_ZERO;
      drop_q <= 16'h0000;
    end else begin
      if (fill_d > peak_q) begin
        peak_q <= fill_d;
      end
      if (push && !push_acc_s && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'h0001;
      end
    end
  end

  assign peak_level = peak_q;
  assign drop_count = drop_q;
`else
  // Statistics outputs are not built in this configuration.
`endif

endmodule
